mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Arbiter and sequencer that shares the single memory port between the pipelined CPU's instruction-fetch path (IF stage) and data path (MEM stage, driven by `d_readM`/`d_writeM` from the control unit). It serializes accesses onto one variable-latency memory handshake. It returns one-cycle completion pulses, which the pipeline uses to release its stalls. Data accesses have priority, and an anti-starvation counter bounds instruction-fetch wait.

## Interface
- `WORD_SIZE`, default 16: data word width.
- `ADDR_SIZE`, default 16: address width.
- `STARVE_LIMIT`, default 3: number of consecutive data grants, made while an instruction request is pending, after which the next grant goes to the instruction side.
- `clk`, in, 1: clock. Single clock domain.
- `reset_n`, in, 1: reset, synchronous and active-low.
- `i_readM`, in, 1: instruction fetch request (level; held until `i_ready` or `i_flush`).
- `i_address`, in, ADDR_SIZE: fetch address.
- `i_flush`, in, 1: discard the outstanding or pending fetch (branch/jump redirect).
- `i_data`, out, WORD_SIZE: fetched word, valid while `i_ready`=1.
- `i_ready`, out, 1: one-cycle fetch-complete pulse.
- `d_readM`, in, 1: data load request (level).
- `d_writeM`, in, 1: data store request (level).
- `d_address`, in, ADDR_SIZE: data address.
- `d_wdata`, in, WORD_SIZE: store data.
- `d_rdata`, out, WORD_SIZE: load data, valid while `d_ready`=1.
- `d_ready`, out, 1: one-cycle data-complete pulse, for both loads and stores.
- `mem_readM`, out, 1: memory read strobe.
- `mem_writeM`, out, 1: memory write strobe.
- `mem_address`, out, ADDR_SIZE: memory address.
- `mem_wdata`, out, WORD_SIZE: memory write data.
- `mem_rdata`, in, WORD_SIZE: memory read data, valid with `mem_ready`.
- `mem_ready`, in, 1: memory completion, one cycle per access.

## Operation
- FSM states: IDLE, I_ACC, D_ACC, RESP.
- **IDLE → D_ACC:** a data request is pending (`d_readM|d_writeM`), and it is not the case that `starve_cnt`==STARVE_LIMIT while `i_readM`=1.
- **IDLE → I_ACC:** `i_readM`=1 and `i_flush`=0, and either there is no data request or `starve_cnt`==STARVE_LIMIT.
- **On grant:** latch address, write data and the op into registers. From then on, `mem_*` come only from those registers, so requester inputs may change freely.
- **If `d_readM` and `d_writeM` are both high:** perform a write.
- **I_ACC / D_ACC:** hold `mem_readM` (or `mem_writeM`) plus address and data stable until `mem_ready`=1. On `mem_ready`, capture `mem_rdata` into the owner's output register and go to RESP. If `mem_ready` is asserted in IDLE or RESP, ignore it.
- **RESP:** lasts exactly one cycle, with all `mem_*` strobes low.
  - Pulse `d_ready`, or pulse `i_ready` only if the fetch was not discarded.
  - Then go to IDLE. Requests are not sampled in RESP.
- **Discard:** `i_flush`=1 in any cycle of I_ACC, or in the I-owned RESP cycle, sets `discard`.
  - The memory access still runs to completion, because memory cannot be aborted.
  - `i_ready` stays 0 for that transaction.
  - `discard` clears on entry to IDLE.
- **Data accesses are never aborted.**
- **Starvation counter `starve_cnt`**, width $clog2(STARVE_LIMIT+1), saturating:
  - +1 on each D grant made while `i_readM`=1.
  - Cleared on each I grant.
  - Cleared when `i_readM`=0 in IDLE.
- **Reset** (`reset_n`=0 at a clock edge), including mid-access:
  - state=IDLE, `starve_cnt`=0, `discard`=0.
  - `i_ready`=`d_ready`=`mem_readM`=`mem_writeM`=0.
  - `i_data`=`d_rdata`=`mem_address`=`mem_wdata`=0.
  - Any in-flight memory access is dropped with no ready pulse.

## Timing
- All outputs are registered, with no combinational input-to-output path.
- Request high in IDLE at cycle 0 → strobe high in cycles 1..n, where `mem_ready` arrives in cycle n ≥ 1 → ready pulse in cycle n+1 → IDLE in cycle n+2.
- With zero-wait memory, the latency from request to ready is 2 cycles and throughput is one access per 3 cycles.
- Requesters must drop or replace their request at the clock edge that ends the ready cycle. A request still high in cycle n+2 is treated as a new access.
- Simultaneous I and D requests in IDLE → D wins (unless starvation applies). I is granted at cycle n+2 of the D access at the earliest.
- `i_flush` arriving in the same cycle as `i_readM` in IDLE → no grant.

## Test plan
- **Single fetch:** `i_readM`=1, addr 0x0010, with memory returning 0xABCD on the first strobe cycle → `mem_readM` high in cycle 1, `i_ready`=1 with `i_data`=0xABCD in cycle 2, `d_ready` stays 0.
- **Contention:** `i_readM` and `d_writeM` (addr 0x0020, data 0x1234) both high at cycle 0, 2-cycle memory latency → write strobe in cycles 1–2, `d_ready` in cycle 3, read strobe in cycles 5–6, `i_ready` in cycle 7.
- **Starvation:** `i_readM` held high, back-to-back data requests, STARVE_LIMIT=3 → exactly 3 D grants, then an I grant, then D resumes.
- **Flush:** `i_flush` pulsed in cycle 2 of a 4-cycle fetch → memory read completes, `i_ready` never pulses, FSM returns to IDLE, and the next fetch proceeds normally.
- **Reset mid-access:** `reset_n`=0 during D_ACC → next cycle all outputs 0 and state IDLE, no `d_ready`, and a late `mem_ready` is ignored.
- **Both `d_readM` and `d_writeM` high:** `mem_writeM`=1 and `mem_readM`=0 for the whole access.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter_if
// Description : Bundle of every handshake/bus signal around the shared memory
//               port: the instruction-fetch requester (i_*), the data
//               requester (d_*) and the single memory handshake (mem_*).
//
//               Port summary
//                 i_readM     fetch request (level)       requester -> arbiter
//                 i_address   fetch address                requester -> arbiter
//                 i_flush     discard pending fetch        requester -> arbiter
//                 i_data      fetched word                 arbiter -> requester
//                 i_ready     fetch-complete pulse         arbiter -> requester
//                 d_readM     load request (level)         requester -> arbiter
//                 d_writeM    store request (level)        requester -> arbiter
//                 d_address   data address                 requester -> arbiter
//                 d_wdata     store data                   requester -> arbiter
//                 d_rdata     load data                    arbiter -> requester
//                 d_ready     data-complete pulse          arbiter -> requester
//                 mem_readM   memory read strobe           arbiter -> memory
//                 mem_writeM  memory write strobe          arbiter -> memory
//                 mem_address memory address               arbiter -> memory
//                 mem_wdata   memory write data            arbiter -> memory
//                 mem_rdata   memory read data             memory  -> arbiter
//                 mem_ready   memory completion            memory  -> arbiter
//
//               Modport master : the arbiter's view (drives pulses and strobes)
//               Modport slave  : the environment's view (requesters + memory)
// Revision    : 1.0  initial release
// ============================================================================
interface mem_port_arbiter_if #(
   parameter int WORD_SIZE = 16,
   parameter int ADDR_SIZE = 16
);
   // instruction-fetch side
   logic                 i_readM;
   logic [ADDR_SIZE-1:0] i_address;
   logic                 i_flush;
   logic [WORD_SIZE-1:0] i_data;
   logic                 i_ready;

   // data side
   logic                 d_readM;
   logic                 d_writeM;
   logic [ADDR_SIZE-1:0] d_address;
   logic [WORD_SIZE-1:0] d_wdata;
   logic [WORD_SIZE-1:0] d_rdata;
   logic                 d_ready;

   // memory side
   logic                 mem_readM;
   logic                 mem_writeM;
   logic [ADDR_SIZE-1:0] mem_address;
   logic [WORD_SIZE-1:0] mem_wdata;
   logic [WORD_SIZE-1:0] mem_rdata;
   logic                 mem_ready;

   modport master (
      input  i_readM, i_address, i_flush,
      output i_data, i_ready,
      input  d_readM, d_writeM, d_address, d_wdata,
      output d_rdata, d_ready,
      output mem_readM, mem_writeM, mem_address, mem_wdata,
      input  mem_rdata, mem_ready
   );

   modport slave (
      output i_readM, i_address, i_flush,
      input  i_data, i_ready,
      output d_readM, d_writeM, d_address, d_wdata,
      input  d_rdata, d_ready,
      input  mem_readM, mem_writeM, mem_address, mem_wdata,
      output mem_rdata, mem_ready
   );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one variable-latency memory port between the pipeline's
//               instruction-fetch path and its data path. Accesses are
//               serialized: grant, hold strobe until mem_ready, one response
//               cycle with a ready pulse, then back to idle. Data wins
//               contention unless the instruction side has been passed over
//               STARVE_LIMIT times in a row while waiting.
//
//               Ports
//                 clk      clock (single domain)
//                 reset_n  synchronous, active-low reset
//                 bus      mem_port_arbiter_if.master (fetch, data and
//                          memory handshake signals)
//
//               Every output is a flop; there is no combinational path from
//               any input to any output.
// Revision    : 1.0  initial release
// ============================================================================
module mem_port_arbiter #(
   parameter int WORD_SIZE    = 16,
   parameter int ADDR_SIZE    = 16,
   parameter int STARVE_LIMIT = 3
) (
   input wire                 clk,
   input wire                 reset_n,
   mem_port_arbiter_if.master bus
);

   // Counter width; kept at least one bit so a zero limit still elaborates.
   localparam int c_cntW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
   localparam logic [c_cntW-1:0] c_starveMax = c_cntW'(STARVE_LIMIT);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_I_ACC = 2'd1,
      S_D_ACC = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   // ---------------------------------------------------------------------
   // State and registered outputs
   // ---------------------------------------------------------------------
   state_t                r_state;
   logic [c_cntW-1:0]     r_starveCnt;
   logic                  r_discard;
   logic                  r_ownerI;      // 1: current/last access belongs to fetch
   logic                  r_memRead;
   logic                  r_memWrite;
   logic [ADDR_SIZE-1:0]  r_memAddress;
   logic [WORD_SIZE-1:0]  r_memWdata;
   logic [WORD_SIZE-1:0]  r_iData;
   logic                  r_iReady;
   logic [WORD_SIZE-1:0]  r_dRdata;
   logic                  r_dReady;

   // ---------------------------------------------------------------------
   // Next-state values
   // ---------------------------------------------------------------------
   state_t                w_stateNext;
   logic [c_cntW-1:0]     w_starveCnt;
   logic                  w_discard;
   logic                  w_ownerI;
   logic                  w_memRead;
   logic                  w_memWrite;
   logic [ADDR_SIZE-1:0]  w_memAddress;
   logic [WORD_SIZE-1:0]  w_memWdata;
   logic [WORD_SIZE-1:0]  w_iData;
   logic                  w_iReady;
   logic [WORD_SIZE-1:0]  w_dRdata;
   logic                  w_dReady;

   logic                  w_dReq;
   logic                  w_starveHit;
   logic                  w_cntSaturated;

   assign w_dReq         = bus.d_readM | bus.d_writeM;
   assign w_cntSaturated = (r_starveCnt == c_starveMax);
   // Fetch has waited long enough: the next grant must go to it.
   assign w_starveHit    = w_cntSaturated & bus.i_readM;

   // ---------------------------------------------------------------------
   // State register (all outputs are flops updated here)
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state      <= S_IDLE;
         r_starveCnt  <= '0;
         r_discard    <= 1'b0;
         r_ownerI     <= 1'b0;
         r_memRead    <= 1'b0;
         r_memWrite   <= 1'b0;
         r_memAddress <= '0;
         r_memWdata   <= '0;
         r_iData      <= '0;
         r_iReady     <= 1'b0;
         r_dRdata     <= '0;
         r_dReady     <= 1'b0;
      end else begin
         r_state      <= w_stateNext;
         r_starveCnt  <= w_starveCnt;
         r_discard    <= w_discard;
         r_ownerI     <= w_ownerI;
         r_memRead    <= w_memRead;
         r_memWrite   <= w_memWrite;
         r_memAddress <= w_memAddress;
         r_memWdata   <= w_memWdata;
         r_iData      <= w_iData;
         r_iReady     <= w_iReady;
         r_dRdata     <= w_dRdata;
         r_dReady     <= w_dReady;
      end
   end

   // ---------------------------------------------------------------------
   // Next-state / output logic
   // ---------------------------------------------------------------------
   always_comb begin
      // Registers hold by default; ready pulses default low.
      w_stateNext  = r_state;
      w_starveCnt  = r_starveCnt;
      w_discard    = r_discard;
      w_ownerI     = r_ownerI;
      w_memRead    = r_memRead;
      w_memWrite   = r_memWrite;
      w_memAddress = r_memAddress;
      w_memWdata   = r_memWdata;
      w_iData      = r_iData;
      w_iReady     = 1'b0;
      w_dRdata     = r_dRdata;
      w_dReady     = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (w_dReq && !w_starveHit) begin
               // Data grant. A simultaneous read+write is treated as a write.
               w_stateNext  = S_D_ACC;
               w_ownerI     = 1'b0;
               w_memAddress = bus.d_address;
               w_memWdata   = bus.d_wdata;
               w_memWrite   = bus.d_writeM;
               w_memRead    = ~bus.d_writeM;
               if (!bus.i_readM) begin
                  w_starveCnt = '0;
               end else if (!w_cntSaturated) begin
                  w_starveCnt = r_starveCnt + 1'b1;
               end
            end else if (bus.i_readM && !bus.i_flush) begin
               // Reached only when there is no data request or the fetch
               // is starving.
               w_stateNext  = S_I_ACC;
               w_ownerI     = 1'b1;
               w_discard    = 1'b0;
               w_memAddress = bus.i_address;
               w_memRead    = 1'b1;
               w_memWrite   = 1'b0;
               w_starveCnt  = '0;
            end else if (!bus.i_readM) begin
               w_starveCnt = '0;
            end
         end

         S_I_ACC: begin
            // Memory cannot be aborted: a flush only suppresses the pulse.
            if (bus.i_flush) begin
               w_discard = 1'b1;
            end
            if (bus.mem_ready) begin
               w_stateNext = S_RESP;
               w_memRead   = 1'b0;
               w_memWrite  = 1'b0;
               w_iData     = bus.mem_rdata;
               w_iReady    = ~(r_discard | bus.i_flush);
            end
         end

         S_D_ACC: begin
            if (bus.mem_ready) begin
               w_stateNext = S_RESP;
               w_memRead   = 1'b0;
               w_memWrite  = 1'b0;
               w_dRdata    = bus.mem_rdata;
               w_dReady    = 1'b1;
            end
         end

         S_RESP: begin
            // The ready pulse is already on its flop during this cycle, so a
            // flush arriving now has nothing left to suppress; the discard
            // flag would be cleared on the way back to idle regardless.
            w_stateNext = S_IDLE;
            w_discard   = 1'b0;
         end

         default: begin
            w_stateNext = S_IDLE;
            w_memRead   = 1'b0;
            w_memWrite  = 1'b0;
            w_discard   = 1'b0;
         end
      endcase
   end

   // ---------------------------------------------------------------------
   // Output mapping
   // ---------------------------------------------------------------------
   assign bus.i_data      = r_iData;
   assign bus.i_ready     = r_iReady;
   assign bus.d_rdata     = r_dRdata;
   assign bus.d_ready     = r_dReady;
   assign bus.mem_readM   = r_memRead;
   assign bus.mem_writeM  = r_memWrite;
   assign bus.mem_address = r_memAddress;
   assign bus.mem_wdata   = r_memWdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Directed, self-checking bench for mem_port_arbiter. A small
//               memory responder raises mem_ready on the memLat-th strobe
//               cycle; each scenario drives requests cycle by cycle and
//               compares outputs against hand-computed values.
// Revision    : 1.0  initial release
// ============================================================================
module tb_mem_port_arbiter;
   localparam int WORD_SIZE    = 16;
   localparam int ADDR_SIZE    = 16;
   localparam int STARVE_LIMIT = 3;

   logic        clk = 1'b0;
   logic        reset_n;
   int          nChecks = 0;
   int          nErrors = 0;

   // memory responder controls
   int          memLat     = 1;
   logic [15:0] memData    = 16'h0000;
   bit          memEn      = 1'b1;
   logic        forceReady = 1'b0;
   int          memCnt     = 0;

   // starvation sequence recorder: 1 = data pulse, 2 = fetch pulse
   int          seqLog [8];
   int          expSeq [5] = '{1, 1, 1, 2, 1};
   int          nPulse;
   logic        sawReady;

   mem_port_arbiter_if #(.WORD_SIZE(WORD_SIZE), .ADDR_SIZE(ADDR_SIZE)) bus ();

   mem_port_arbiter #(
      .WORD_SIZE   (WORD_SIZE),
      .ADDR_SIZE   (ADDR_SIZE),
      .STARVE_LIMIT(STARVE_LIMIT)
   ) dut (
      .clk    (clk),
      .reset_n(reset_n),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   // Memory model: runs after the stimulus update of each cycle.
   always @(posedge clk) begin
      #3;
      if (!memEn) begin
         memCnt        = 0;
         bus.mem_ready = forceReady;
      end else if (bus.mem_readM || bus.mem_writeM) begin
         memCnt = memCnt + 1;
         if (memCnt == memLat) begin
            bus.mem_ready = 1'b1;
            bus.mem_rdata = memData;
            memCnt        = 0;
         end else begin
            bus.mem_ready = 1'b0;
         end
      end else begin
         memCnt        = 0;
         bus.mem_ready = 1'b0;
      end
   end

   task automatic checkValue(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
      nChecks++;
      if (actual !== expected) begin
         nErrors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
      end
   endtask

   // Advance to the next cycle; inputs are driven right after the edge.
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic checkAllZero(input string tag);
      checkValue({tag, " i_ready"},     32'(bus.i_ready),     32'h0);
      checkValue({tag, " d_ready"},     32'(bus.d_ready),     32'h0);
      checkValue({tag, " mem_readM"},   32'(bus.mem_readM),   32'h0);
      checkValue({tag, " mem_writeM"},  32'(bus.mem_writeM),  32'h0);
      checkValue({tag, " mem_address"}, 32'(bus.mem_address), 32'h0);
      checkValue({tag, " mem_wdata"},   32'(bus.mem_wdata),   32'h0);
      checkValue({tag, " i_data"},      32'(bus.i_data),      32'h0);
      checkValue({tag, " d_rdata"},     32'(bus.d_rdata),     32'h0);
   endtask

   initial begin
      reset_n       = 1'b0;
      bus.i_readM   = 1'b0;
      bus.i_address = '0;
      bus.i_flush   = 1'b0;
      bus.d_readM   = 1'b0;
      bus.d_writeM  = 1'b0;
      bus.d_address = '0;
      bus.d_wdata   = '0;

      // ---------------- reset state
      repeat (3) tick();
      @(negedge clk);
      checkAllZero("reset");
      tick();
      reset_n = 1'b1;

      // ---------------- single fetch, zero-wait memory
      memLat = 1; memData = 16'hABCD;
      tick(); bus.i_readM = 1'b1; bus.i_address = 16'h0010;
      @(negedge clk);
      checkValue("fetch c0 mem_readM", 32'(bus.mem_readM), 32'h0);
      tick(); @(negedge clk);
      checkValue("fetch c1 mem_readM", 32'(bus.mem_readM), 32'h1);
      checkValue("fetch c1 mem_address", 32'(bus.mem_address), 32'h0010);
      tick(); bus.i_readM = 1'b0; @(negedge clk);
      checkValue("fetch c2 i_ready", 32'(bus.i_ready), 32'h1);
      checkValue("fetch c2 i_data", 32'(bus.i_data), 32'hABCD);
      checkValue("fetch c2 d_ready", 32'(bus.d_ready), 32'h0);
      checkValue("fetch c2 mem_readM", 32'(bus.mem_readM), 32'h0);
      tick(); @(negedge clk);
      checkValue("fetch c3 i_ready", 32'(bus.i_ready), 32'h0);

      // ---------------- contention: D write wins, then fetch
      memLat = 2; memData = 16'h5A5A;
      tick();
      bus.i_readM = 1'b1; bus.i_address = 16'h0030;
      bus.d_writeM = 1'b1; bus.d_address = 16'h0020; bus.d_wdata = 16'h1234;
      tick(); @(negedge clk);
      checkValue("cont c1 mem_writeM", 32'(bus.mem_writeM), 32'h1);
      checkValue("cont c1 mem_readM", 32'(bus.mem_readM), 32'h0);
      checkValue("cont c1 mem_address", 32'(bus.mem_address), 32'h0020);
      checkValue("cont c1 mem_wdata", 32'(bus.mem_wdata), 32'h1234);
      tick(); @(negedge clk);
      checkValue("cont c2 mem_writeM", 32'(bus.mem_writeM), 32'h1);
      tick(); bus.d_writeM = 1'b0; @(negedge clk);
      checkValue("cont c3 d_ready", 32'(bus.d_ready), 32'h1);
      checkValue("cont c3 i_ready", 32'(bus.i_ready), 32'h0);
      checkValue("cont c3 mem_writeM", 32'(bus.mem_writeM), 32'h0);
      tick(); @(negedge clk);
      checkValue("cont c4 d_ready", 32'(bus.d_ready), 32'h0);
      checkValue("cont c4 mem_readM", 32'(bus.mem_readM), 32'h0);
      tick(); @(negedge clk);
      checkValue("cont c5 mem_readM", 32'(bus.mem_readM), 32'h1);
      checkValue("cont c5 mem_address", 32'(bus.mem_address), 32'h0030);
      tick(); @(negedge clk);
      checkValue("cont c6 mem_readM", 32'(bus.mem_readM), 32'h1);
      tick(); bus.i_readM = 1'b0; @(negedge clk);
      checkValue("cont c7 i_ready", 32'(bus.i_ready), 32'h1);
      checkValue("cont c7 i_data", 32'(bus.i_data), 32'h5A5A);

      // ---------------- starvation: expect D D D I D
      memLat = 1; memData = 16'h3C3C;
      tick();
      bus.i_readM = 1'b1; bus.i_address = 16'h0100;
      bus.d_readM = 1'b1; bus.d_address = 16'h0200;
      nPulse = 0;
      for (int k = 0; k < 15; k++) begin
         if (k > 0) tick();
         @(negedge clk);
         if (bus.d_ready) begin
            if (nPulse < 8) seqLog[nPulse] = 1;
            nPulse++;
         end
         if (bus.i_ready) begin
            if (nPulse < 8) seqLog[nPulse] = 2;
            nPulse++;
         end
      end
      bus.i_readM = 1'b0; bus.d_readM = 1'b0;
      checkValue("starve pulse count", 32'(nPulse), 32'd5);
      for (int k = 0; k < 5; k++) begin
         if (k < nPulse) checkValue($sformatf("starve grant %0d", k), 32'(seqLog[k]), 32'(expSeq[k]));
      end

      // ---------------- flush mid-fetch, 4-cycle memory
      memLat = 4; memData = 16'hBEEF; sawReady = 1'b0;
      tick(); bus.i_readM = 1'b1; bus.i_address = 16'h0040;
      tick(); @(negedge clk);
      checkValue("flush c1 mem_readM", 32'(bus.mem_readM), 32'h1);
      sawReady |= bus.i_ready;
      tick(); bus.i_flush = 1'b1; bus.i_readM = 1'b0; @(negedge clk);
      sawReady |= bus.i_ready;
      tick(); bus.i_flush = 1'b0; @(negedge clk);
      sawReady |= bus.i_ready;
      tick(); @(negedge clk);
      checkValue("flush c4 mem_readM", 32'(bus.mem_readM), 32'h1);
      sawReady |= bus.i_ready;
      tick(); @(negedge clk);
      checkValue("flush c5 mem_readM", 32'(bus.mem_readM), 32'h0);
      sawReady |= bus.i_ready;
      tick();
      memLat = 1; memData = 16'h1111;
      bus.i_readM = 1'b1; bus.i_address = 16'h0042;
      @(negedge clk);
      sawReady |= bus.i_ready;
      checkValue("flush no i_ready", 32'(sawReady), 32'h0);
      tick(); @(negedge clk);
      checkValue("refetch c7 mem_readM", 32'(bus.mem_readM), 32'h1);
      checkValue("refetch c7 mem_address", 32'(bus.mem_address), 32'h0042);
      tick(); bus.i_readM = 1'b0; @(negedge clk);
      checkValue("refetch c8 i_ready", 32'(bus.i_ready), 32'h1);
      checkValue("refetch c8 i_data", 32'(bus.i_data), 32'h1111);
      // flush together with request in idle: no grant
      tick(); bus.i_readM = 1'b1; bus.i_flush = 1'b1;
      tick(); bus.i_readM = 1'b0; bus.i_flush = 1'b0; @(negedge clk);
      checkValue("flush-in-idle mem_readM", 32'(bus.mem_readM), 32'h0);

      // ---------------- reset in the middle of a data access
      memEn = 1'b0; forceReady = 1'b0;
      tick(); bus.d_readM = 1'b1; bus.d_address = 16'h0050;
      tick(); @(negedge clk);
      checkValue("rst c1 mem_readM", 32'(bus.mem_readM), 32'h1);
      tick(); reset_n = 1'b0; bus.d_readM = 1'b0; @(negedge clk);
      checkValue("rst c2 mem_readM held", 32'(bus.mem_readM), 32'h1);
      tick(); reset_n = 1'b1; forceReady = 1'b1; @(negedge clk);
      checkAllZero("rst c3");
      tick(); forceReady = 1'b0; @(negedge clk);
      checkValue("rst c4 d_ready", 32'(bus.d_ready), 32'h0);
      checkValue("rst c4 mem_readM", 32'(bus.mem_readM), 32'h0);
      memEn = 1'b1;

      // ---------------- read and write both high: write wins
      memLat = 2; memData = 16'h0000;
      tick();
      bus.d_readM = 1'b1; bus.d_writeM = 1'b1;
      bus.d_address = 16'h0060; bus.d_wdata = 16'h7777;
      tick(); @(negedge clk);
      checkValue("rw c1 mem_writeM", 32'(bus.mem_writeM), 32'h1);
      checkValue("rw c1 mem_readM", 32'(bus.mem_readM), 32'h0);
      checkValue("rw c1 mem_wdata", 32'(bus.mem_wdata), 32'h7777);
      checkValue("rw c1 mem_address", 32'(bus.mem_address), 32'h0060);
      tick(); @(negedge clk);
      checkValue("rw c2 mem_writeM", 32'(bus.mem_writeM), 32'h1);
      checkValue("rw c2 mem_readM", 32'(bus.mem_readM), 32'h0);
      tick(); bus.d_readM = 1'b0; bus.d_writeM = 1'b0; @(negedge clk);
      checkValue("rw c3 d_ready", 32'(bus.d_ready), 32'h1);
      checkValue("rw c3 mem_writeM", 32'(bus.mem_writeM), 32'h0);

      tick();
      $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
      $finish;
   end
endmodule
`default_nettype wire
